alu_issue: RTL and testbench

Decode/issue stage directly upstream of the 16-bit ALU. Accepts instruction words over a valid/ready handshake and reads operands from an internal register file. Drives function code and operands into the ALU, then writes the ALU's registered result (and remainder) back. It contains a two-entry scoreboard that stalls read-after-write hazards across the ALU's one-cycle latency.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_issue_if.sv | 24 ++
 rtl/alu_regfile.sv | 46 ++++
 rtl/alu_issue.sv | 120 ++++++++++++
 tb/tb_alu_issue.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decode/issue stage: opcodes, instruction fields and
// scoreboard entry layout.
package alu_pkg;

    localparam int unsigned W  = 16;
    localparam int unsigned RW = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0111;
    localparam logic [3:0] OP_SWP = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;

    typedef enum logic [1:0] {
        WB_ONE,
        WB_MULDIV,
        WB_SWAP
    } wb_kind_e;

    typedef struct packed {
        logic            valid;
        wb_kind_e        kind;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [W-1:0]    op2;
    } sb_entry_t;

    function automatic logic is_issued(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL) ||
               (opc == OP_DIV) || (opc == OP_MOV) || (opc == OP_SWP);
    endfunction

    // True when register a is among the destinations of a valid in-flight entry.
    function automatic logic sb_hit(input sb_entry_t e, input logic [RW-1:0] a,
                                    input logic [RW-1:0] hi);
        return e.valid && ((e.rd == a) ||
                           ((e.kind == WB_MULDIV) && (hi == a)) ||
                           ((e.kind == WB_SWAP) && (e.rs1 == a)));
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake and ALU operand/result bus between issue stage and its neighbours.
interface alu_issue_if;
    import alu_pkg::*;

    logic         instr_valid;
    logic [15:0]  instr;
    logic         instr_ready;
    logic [3:0]   alu_funct;
    logic [W-1:0] alu_op1;
    logic [W-1:0] alu_op2;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_remainder;

    modport slave (
        input  instr_valid, instr, alu_result, alu_remainder,
        output instr_ready, alu_funct, alu_op1, alu_op2
    );

    modport master (
        output instr_valid, instr, alu_result, alu_remainder,
        input  instr_ready, alu_funct, alu_op1, alu_op2
    );

endinterface

// File: rtl/alu_regfile.sv
// NREG x W register file: three combinational read ports, two write ports (A wins on
// address collision), asynchronous active-low reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rs1_addr,
    input  logic [RW-1:0] rs2_addr,
    input  logic [RW-1:0] dbg_addr,
    output logic [W-1:0]  rs1_data,
    output logic [W-1:0]  rs2_data,
    output logic [W-1:0]  dbg_data,
    input  logic          we_a,
    input  logic [RW-1:0] wa_a,
    input  logic [W-1:0]  wd_a,
    input  logic          we_b,
    input  logic [RW-1:0] wa_b,
    input  logic [W-1:0]  wd_b
);

    logic [W-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_a && (wa_a == RW'(i))) begin
                    mem_q[i] <= wd_a;
                end else if (we_b && (wa_b == RW'(i))) begin
                    mem_q[i] <= wd_b;
                end
            end
        end
    end

    assign rs1_data = mem_q[rs1_addr];
    assign rs2_data = mem_q[rs2_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage for the 16-bit ALU: operand read, two-entry RAW/WAW scoreboard
// spanning the ALU latency, and writeback of result/remainder.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_if.slave    bus,
    input  logic [RW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    output logic          div0,
    output logic          busy
);

    localparam logic [RW-1:0] HI = RW'(NREG - 1);

    logic [3:0]    opc;
    logic [RW-1:0] rd, rs1, rs2;
    logic [W-1:0]  rs1_data, rs2_data;
    logic          issued, muldiv, is_mov, hazard, accept, div_zero, go;
    wb_kind_e      kind;

    sb_entry_t     t1_q, t2_q;
    logic [3:0]    funct_q;
    logic [W-1:0]  op1_q, op2_q;
    logic          div0_q;

    logic          we_a, we_b;
    logic [RW-1:0] wa_a, wa_b;
    logic [W-1:0]  wd_a, wd_b;

    assign opc = bus.instr[OPC_MSB:OPC_LSB];
    assign rd  = bus.instr[RD_MSB:RD_LSB];
    assign rs1 = bus.instr[RS1_MSB:RS1_LSB];
    assign rs2 = bus.instr[RS2_MSB:RS2_LSB];

    always_comb begin
        issued = is_issued(opc);
        muldiv = (opc == OP_MUL) || (opc == OP_DIV);
        is_mov = (opc == OP_MOV);
        kind   = muldiv ? WB_MULDIV : ((opc == OP_SWP) ? WB_SWAP : WB_ONE);
        // No bypass: any overlap with an in-flight destination stalls until writeback.
        hazard = issued &&
                 (sb_hit(t1_q, rs1, HI) || sb_hit(t2_q, rs1, HI) ||
                  (!is_mov && (sb_hit(t1_q, rs2, HI) || sb_hit(t2_q, rs2, HI))) ||
                  sb_hit(t1_q, rd, HI) || sb_hit(t2_q, rd, HI) ||
                  (muldiv && (sb_hit(t1_q, HI, HI) || sb_hit(t2_q, HI, HI))));
        accept   = bus.instr_valid && !hazard;
        div_zero = (opc == OP_DIV) && (rs2_data == '0);
        go       = accept && issued && !div_zero;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            funct_q <= OP_NOP;
            op1_q   <= '0;
            op2_q   <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            t2_q <= t1_q;
            if (go) begin
                funct_q <= opc;
                op1_q   <= rs1_data;
                op2_q   <= rs2_data;
                t1_q    <= '{valid: 1'b1, kind: kind, rd: rd, rs1: rs1, op2: rs2_data};
            end else begin
                funct_q <= OP_NOP;
                t1_q    <= '0;
            end
            if (accept && div_zero) begin
                div0_q <= 1'b1;
            end
        end
    end

    // Port A carries rd so it wins over HI / swap-source on a collision.
    always_comb begin
        we_a = t2_q.valid;
        wa_a = t2_q.rd;
        wd_a = bus.alu_result;
        we_b = t2_q.valid && (t2_q.kind != WB_ONE);
        wa_b = HI;
        wd_b = bus.alu_remainder;
        if (t2_q.kind == WB_SWAP) begin
            wa_b = t2_q.rs1;
            wd_b = t2_q.op2;
        end
    end

    alu_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .dbg_addr (dbg_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dbg_data (dbg_data),
        .we_a     (we_a),
        .wa_a     (wa_a),
        .wd_a     (wd_a),
        .we_b     (we_b),
        .wa_b     (wa_b),
        .wd_b     (wd_b)
    );

    assign bus.instr_ready = !hazard;
    assign bus.alu_funct   = funct_q;
    assign bus.alu_op1     = op1_q;
    assign bus.alu_op2     = op2_q;
    assign div0            = div0_q;
    assign busy            = t1_q.valid || t2_q.valid;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU stand-in, sequential reference model of the
// register file, and a per-register "pending until" model of issue stalls.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int unsigned NREG = 16;
    localparam logic [3:0]  HI   = 4'(NREG - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus ();
    logic [RW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;
    logic          div0, busy;

    alu_issue #(
        .NREG (NREG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .div0     (div0),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: registered result, holds on funct 1111; MOV may return an injected value.
    logic         inj_on = 1'b0;
    logic [W-1:0] inj_val = '0;
    logic [W-1:0] alu_res_d, alu_rem_d;

    always_comb begin
        int a, b;
        logic [31:0] p;
        a = $signed(bus.alu_op1);
        b = $signed(bus.alu_op2);
        p = 32'(a * b);
        alu_res_d = bus.alu_result;
        alu_rem_d = bus.alu_remainder;
        case (bus.alu_funct)
            OP_ADD: alu_res_d = bus.alu_op1 + bus.alu_op2;
            OP_SUB: alu_res_d = bus.alu_op1 - bus.alu_op2;
            OP_MUL: begin alu_res_d = p[15:0]; alu_rem_d = p[31:16]; end
            OP_DIV: if (b != 0) begin alu_res_d = 16'(a / b); alu_rem_d = 16'(a % b); end
            OP_MOV: alu_res_d = inj_on ? inj_val : bus.alu_op1;
            OP_SWP: alu_res_d = bus.alu_op1;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (bus.alu_funct != OP_NOP) begin
            bus.alu_result    <= alu_res_d;
            bus.alu_remainder <= alu_rem_d;
        end
    end

    // Reference state: architectural registers, sticky flag, and per-register earliest
    // edge at which an instruction touching that register may be accepted.
    logic [W-1:0] ref_r [NREG];
    int           busy_until [NREG];
    logic         ref_div0;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            ref_r[i] = '0;
            busy_until[i] = 0;
        end
        ref_div0 = 1'b0;
    endtask

    function automatic logic real_op(input logic [3:0] o);
        return o inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOV, OP_SWP};
    endfunction

    function automatic logic model_ready(input logic [15:0] ins, input int k);
        logic [3:0] o, d, s1, s2;
        {o, d, s1, s2} = ins;
        if (!real_op(o)) return 1'b1;
        if (busy_until[s1] > k || busy_until[d] > k) return 1'b0;
        if (o != OP_MOV && busy_until[s2] > k) return 1'b0;
        if ((o == OP_MUL || o == OP_DIV) && busy_until[HI] > k) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_accept(input logic [15:0] ins, input int k);
        logic [3:0]  o, d, s1, s2;
        logic [W-1:0] a, b;
        int ia, ib;
        logic [31:0] p;
        {o, d, s1, s2} = ins;
        a  = ref_r[s1];
        b  = ref_r[s2];
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            OP_ADD: begin ref_r[d] = a + b; busy_until[d] = k + 3; end
            OP_SUB: begin ref_r[d] = a - b; busy_until[d] = k + 3; end
            OP_MOV: begin ref_r[d] = a;     busy_until[d] = k + 3; end
            OP_MUL: begin
                p = 32'(ia * ib);
                ref_r[HI] = p[31:16];
                ref_r[d]  = p[15:0];
                busy_until[HI] = k + 3;
                busy_until[d]  = k + 3;
            end
            OP_DIV: begin
                if (b == '0) begin
                    ref_div0 = 1'b1;
                end else begin
                    ref_r[HI] = 16'(ia % ib);
                    ref_r[d]  = 16'(ia / ib);
                    busy_until[HI] = k + 3;
                    busy_until[d]  = k + 3;
                end
            end
            OP_SWP: begin
                ref_r[s1] = b;
                ref_r[d]  = a;
                busy_until[s1] = k + 3;
                busy_until[d]  = k + 3;
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] o, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2);
        return {o, d, s1, s2};
    endfunction

    // Present ins until accepted; stalls returns the number of cycles ready was low.
    task automatic issue(input logic [15:0] ins, output int stalls);
        int k;
        logic er;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        stalls = 0;
        forever begin
            #1;
            er = model_ready(ins, cyc + 1);
            check($sformatf("instr_ready %h", ins), 32'(bus.instr_ready), 32'(er));
            if (bus.instr_ready) break;
            stalls++;
            if (stalls > 6) begin
                check("stall_bound", 32'(stalls), 32'(6));
                bus.instr_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        k = cyc + 1;
        @(posedge clk);
        model_accept(ins, k);
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            dbg_addr = 4'(i);
            #1;
            check($sformatf("%s R%0d", tag, i), 32'(dbg_data), 32'(ref_r[i]));
        end
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [W-1:0] v);
        dbg_addr = 4'(idx);
        #1;
        check(tag, 32'(dbg_data), 32'(v));
    endtask

    task automatic preload(input logic [3:0] r, input logic [W-1:0] v);
        int s;
        inj_val = v;
        inj_on  = 1'b1;
        issue(mk(OP_MOV, r, 4'd0, 4'd0), s);
        idle(4);
        ref_r[r] = v;
        inj_on = 1'b0;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) :
                                             4'($urandom_range(0, 4));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        logic [3:0] o;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        dbg_addr = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset funct", 32'(bus.alu_funct), 32'(4'b1111));
        rst = 1'b1;
        @(negedge clk);
        check_regs("reset");
        check("reset funct", 32'(bus.alu_funct), 32'(4'b1111));
        check("reset op1", 32'(bus.alu_op1), 32'(0));
        check("reset op2", 32'(bus.alu_op2), 32'(0));
        check("reset ready", 32'(bus.instr_ready), 32'(1));
        check("reset div0", 32'(div0), 32'(0));
        check("reset busy", 32'(busy), 32'(0));

        // add with ALU-side observation one edge after accept
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd7);
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), s);
        @(negedge clk);
        check("add funct", 32'(bus.alu_funct), 32'(4'b0000));
        check("add op1", 32'(bus.alu_op1), 32'(5));
        check("add op2", 32'(bus.alu_op2), 32'(7));
        check("add busy", 32'(busy), 32'(1));
        idle(3);
        check_reg("add R3", 3, 16'd12);

        // RAW hazard: two stall cycles
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), s);
        issue(mk(OP_SUB, 4'd4, 4'd3, 4'd1), s);
        check("raw stalls", 32'(s), 32'(2));
        idle(4);
        check_reg("sub R4", 4, 16'd7);

        // signed divide, then divide by zero
        preload(4'd1, 16'hFFF9);
        preload(4'd2, 16'd2);
        issue(mk(OP_DIV, 4'd5, 4'd1, 4'd2), s);
        idle(4);
        check_reg("div R5", 5, 16'hFFFD);
        check_reg("div R15", 15, 16'hFFFF);
        issue(mk(OP_DIV, 4'd6, 4'd1, 4'd0), s);
        @(negedge clk);
        check("div0 funct", 32'(bus.alu_funct), 32'(4'b1111));
        check("div0 flag", 32'(div0), 32'(1));
        check("div0 busy", 32'(busy), 32'(0));
        idle(4);
        check_reg("div0 R6", 6, 16'd0);
        check_regs("div");

        // swap with rd==rs1, then ordinary swap
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd7);
        issue(mk(OP_SWP, 4'd1, 4'd1, 4'd2), s);
        idle(4);
        check_reg("swap1 R1", 1, 16'd5);
        check_reg("swap1 R2", 2, 16'd7);
        issue(mk(OP_SWP, 4'd3, 4'd1, 4'd2), s);
        idle(4);
        check_reg("swap2 R3", 3, 16'd5);
        check_reg("swap2 R1", 1, 16'd7);
        check_regs("swap");

        // reset while an add is in flight
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), s);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(3);
        check_regs("midreset");
        check("midreset div0", 32'(div0), 32'(0));
        check("midreset busy", 32'(busy), 32'(0));
        check("midreset funct", 32'(bus.alu_funct), 32'(4'b1111));

        // independent adds back to back
        preload(4'd1, 16'd3);
        preload(4'd2, 16'd4);
        issue(mk(OP_ADD, 4'd3, 4'd1, 4'd2), s);
        check("b2b stall0", 32'(s), 32'(0));
        issue(mk(OP_ADD, 4'd4, 4'd1, 4'd2), s);
        check("b2b stall1", 32'(s), 32'(0));
        issue(mk(OP_SUB, 4'd5, 4'd1, 4'd2), s);
        check("b2b stall2", 32'(s), 32'(0));
        issue(mk(OP_NOP, 4'd1, 4'd1, 4'd1), s);
        check("b2b nop", 32'(s), 32'(0));
        idle(4);
        check_reg("b2b R5", 5, 16'hFFFF);
        check_regs("b2b");

        // randomized program against the reference model
        for (int i = 1; i < NREG - 1; i++) begin
            preload(4'(i), 16'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0: o = OP_ADD;
                1: o = OP_SUB;
                2: o = OP_MUL;
                3: o = OP_DIV;
                4: o = OP_MOV;
                5: o = OP_SWP;
                default: o = 4'($urandom_range(9, 15));
            endcase
            issue(mk(o, rnd_reg(), rnd_reg(), rnd_reg()), s);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(4);
        check_regs("random");
        check("random div0", 32'(div0), 32'(ref_div0));
        check("random busy", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
